mem_bus_arbiter: RTL and testbench

Round-robin arbiter that shares the demo SoC's single 32-bit memory bus (SRAM and hardware registers at 0xFF00_xxxx) between NUM_REQ requesters, e.g. the vector processor and a UART boot/debug loader. It grants one request per cycle, optionally holds the bus for a locked requester, and tracks outstanding accesses in a fixed-latency pipeline so that every read/write response is routed back to the requester that issued it.

---
 rtl/demo_pkg.sv | 27 ++
 rtl/mem_arb_rr.sv | 109 ++++++++++
 rtl/mem_bus_arbiter.sv | 98 +++++++++
 tb/tb_mem_bus_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/demo_pkg.sv
// Shared types and helpers for the memory bus arbiter.
package demo_pkg;

  // Width of the index field carried through the response routing pipe.
  // Wide enough for any practical requester count; unused upper bits stay zero.
  localparam int unsigned ROUTE_IDX_W = 8;

  // Bits needed to index NUM_REQ requesters (never less than one).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index width for the default two-requester configuration.
  localparam int unsigned IDX_W = idx_width(2);

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // One slot of the response routing pipe: is a response owed, and to whom.
  typedef struct packed {
    logic                   valid;
    logic [ROUTE_IDX_W-1:0] idx;
  } route_entry_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Round-robin pick with optional bus lock; owns the priority pointer.
module mem_arb_rr
  import demo_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned IDX_BITS = idx_width(NUM_REQ)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [NUM_REQ-1:0]  lock_i,
  output logic [NUM_REQ-1:0]  gnt_o,
  output logic [IDX_BITS-1:0] gnt_idx_o,
  output logic                gnt_any_o
);

  arb_state_e          r_state;
  arb_state_e          w_state_next;
  logic [IDX_BITS-1:0] r_ptr;
  logic [IDX_BITS-1:0] w_ptr_next;
  logic [IDX_BITS-1:0] r_owner;
  logic [IDX_BITS-1:0] w_owner_next;
  logic                w_pick_any;
  logic [IDX_BITS-1:0] w_pick_idx;
  logic [IDX_BITS-1:0] w_cand [NUM_REQ];

  // Successor index with wrap-around.
  function automatic logic [IDX_BITS-1:0] f_inc(input logic [IDX_BITS-1:0] i);
    if (i == IDX_BITS'(NUM_REQ - 1)) return '0;
    return i + IDX_BITS'(1);
  endfunction

  // Candidate gi is the requester gi places after the pointer, modulo NUM_REQ.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [IDX_BITS:0] w_sum;
    assign w_sum = {1'b0, r_ptr} + (IDX_BITS+1)'(gi);
    assign w_cand[gi] = (w_sum >= (IDX_BITS+1)'(NUM_REQ))
                      ? IDX_BITS'(w_sum - (IDX_BITS+1)'(NUM_REQ))
                      : IDX_BITS'(w_sum);
  end

  // Search from the pointer; a locked bus only considers its owner.
  always_comb begin
    w_pick_any = 1'b0;
    w_pick_idx = '0;
    if (r_state == ARB_LOCKED) begin
      w_pick_any = req_i[r_owner];
      w_pick_idx = r_owner;
    end else begin
      // Walk backwards so the candidate nearest the pointer wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (req_i[w_cand[k]]) begin
          w_pick_any = 1'b1;
          w_pick_idx = w_cand[k];
        end
      end
    end
  end

  // State register: arbitration state, lock owner and priority pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ARB_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_owner <= w_owner_next;
    end
  end

  // Next state: rotate after unlocked grants, park the pointer while locked.
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_owner_next = r_owner;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_any) begin
          if (lock_i[w_pick_idx]) begin
            w_state_next = ARB_LOCKED;
            w_owner_next = w_pick_idx;
          end else begin
            w_ptr_next = f_inc(w_pick_idx);
          end
        end
      end
      ARB_LOCKED: begin
        // lock_i only matters when the owner is actually being granted.
        if (!req_i[r_owner] || !lock_i[r_owner]) begin
          w_state_next = ARB_IDLE;
          w_ptr_next   = f_inc(r_owner);
        end
      end
      default: w_state_next = ARB_IDLE;
    endcase
  end

  // Outputs: one-hot grant, held low while reset is asserted.
  always_comb begin
    gnt_o = '0;
    if (!rst_i && w_pick_any) gnt_o[w_pick_idx] = 1'b1;
  end

  assign gnt_idx_o = w_pick_idx;
  assign gnt_any_o = w_pick_any & ~rst_i;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between NUM_REQ requesters and routes each
// fixed-latency response back to the requester that issued it.
module mem_bus_arbiter
  import demo_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        lock_i,
  input  logic [NUM_REQ-1:0][31:0]  addr_i,
  input  logic [NUM_REQ-1:0]        we_i,
  input  logic [NUM_REQ-1:0][3:0]   be_i,
  input  logic [NUM_REQ-1:0][31:0]  wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic                      err_o,
  output logic [31:0]               rdata_o,
  output logic                      mem_req_o,
  output logic [31:0]               mem_addr_o,
  output logic                      mem_we_o,
  output logic [3:0]                mem_be_o,
  output logic [31:0]               mem_wdata_o,
  input  logic                      mem_rvalid_i,
  input  logic                      mem_err_i,
  input  logic [31:0]               mem_rdata_i,
  output logic                      mismatch_o
);

  localparam int unsigned IDX_BITS = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]  w_gnt;
  logic [IDX_BITS-1:0] w_gnt_idx;
  logic                w_gnt_any;
  route_entry_t        r_pipe [MEM_LAT];
  route_entry_t        w_stage0;
  route_entry_t        w_tail;
  logic                w_hit;

  mem_arb_rr #(
    .NUM_REQ  (NUM_REQ),
    .IDX_BITS (IDX_BITS)
  ) u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .lock_i    (lock_i),
    .gnt_o     (w_gnt),
    .gnt_idx_o (w_gnt_idx),
    .gnt_any_o (w_gnt_any)
  );

  assign gnt_o     = w_gnt;
  assign mem_req_o = |w_gnt;

  // Forward the granted requester's payload; every field idles at zero.
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (w_gnt_any) begin
      mem_addr_o  = addr_i[w_gnt_idx];
      mem_we_o    = we_i[w_gnt_idx];
      mem_be_o    = be_i[w_gnt_idx];
      mem_wdata_o = wdata_i[w_gnt_idx];
    end
  end

  assign w_stage0.valid = w_gnt_any;
  assign w_stage0.idx   = ROUTE_IDX_W'(w_gnt_idx);

  // Routing pipe: one slot per cycle of memory latency, tail meets the response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < MEM_LAT; s++) r_pipe[s] <= '0;
    end else begin
      r_pipe[0] <= w_stage0;
      for (int s = 1; s < MEM_LAT; s++) r_pipe[s] <= r_pipe[s-1];
    end
  end

  assign w_tail = r_pipe[MEM_LAT-1];
  assign w_hit  = ~rst_i & w_tail.valid & mem_rvalid_i;

  // Steer a matched response to the requester recorded at issue time.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_route
    assign rvalid_o[gi] = w_hit & (w_tail.idx == ROUTE_IDX_W'(gi));
  end

  // Data and error are broadcast; a stray or missing response is flagged.
  assign err_o      = ~rst_i & mem_err_i;
  assign rdata_o    = rst_i ? 32'h0 : mem_rdata_i;
  assign mismatch_o = ~rst_i & (w_tail.valid ^ mem_rvalid_i);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: two arbiters (latency 1 and 3) share one stimulus stream.
module tb_mem_bus_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req, lock, we;
  logic [1:0][31:0] addr, wdata;
  logic [1:0][3:0]  be;
  logic             inject, drop;

  logic [1:0]  o_gnt [2];
  logic [1:0]  o_rvalid [2];
  logic        o_err [2];
  logic [31:0] o_rdata [2];
  logic        o_mreq [2];
  logic [31:0] o_maddr [2];
  logic        o_mwe [2];
  logic [3:0]  o_mbe [2];
  logic [31:0] o_mwd [2];
  logic        o_mism [2];
  logic        m_rvalid [2];
  logic        m_err [2];
  logic [31:0] m_rdata [2];

  int cyc_n = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int cyc; logic [1:0] gnt; logic [31:0] a; logic w; logic [3:0] b; logic [31:0] d;
  } gexp_t;
  typedef struct {
    int cyc; logic [1:0] gnt; logic e; logic [31:0] d;
  } rexp_t;

  gexp_t qg [2][$];
  rexp_t qr [2][$];
  int    qm [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  mem_bus_arbiter #(.NUM_REQ(2), .MEM_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .gnt_o(o_gnt[0]), .rvalid_o(o_rvalid[0]),
    .err_o(o_err[0]), .rdata_o(o_rdata[0]), .mem_req_o(o_mreq[0]), .mem_addr_o(o_maddr[0]),
    .mem_we_o(o_mwe[0]), .mem_be_o(o_mbe[0]), .mem_wdata_o(o_mwd[0]),
    .mem_rvalid_i(m_rvalid[0]), .mem_err_i(m_err[0]), .mem_rdata_i(m_rdata[0]),
    .mismatch_o(o_mism[0])
  );

  mem_bus_arbiter #(.NUM_REQ(2), .MEM_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .gnt_o(o_gnt[1]), .rvalid_o(o_rvalid[1]),
    .err_o(o_err[1]), .rdata_o(o_rdata[1]), .mem_req_o(o_mreq[1]), .mem_addr_o(o_maddr[1]),
    .mem_we_o(o_mwe[1]), .mem_be_o(o_mbe[1]), .mem_wdata_o(o_mwd[1]),
    .mem_rvalid_i(m_rvalid[1]), .mem_err_i(m_err[1]), .mem_rdata_i(m_rdata[1]),
    .mismatch_o(o_mism[1])
  );

  function automatic int lat(input int j);
    return (j == 0) ? 1 : 3;
  endfunction

  // Contents of the modelled SRAM / register space.
  function automatic logic [31:0] sram_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Downstream memory: fixed latency, errors in 0xBAD0_xxxx, writes return 0.
  typedef struct packed { logic v; logic e; logic [31:0] d; } rsp_t;
  rsp_t rp1;
  rsp_t rp3 [3];

  function automatic rsp_t mk_rsp(input logic rq, input logic [31:0] a, input logic w);
    rsp_t x;
    x.v = rq & ~drop;
    x.e = (a[31:16] == 16'hBAD0);
    x.d = w ? 32'h0 : sram_word(a);
    return x;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      rp1 <= '0; rp3[0] <= '0; rp3[1] <= '0; rp3[2] <= '0;
    end else begin
      rp1    <= mk_rsp(o_mreq[0], o_maddr[0], o_mwe[0]);
      rp3[0] <= mk_rsp(o_mreq[1], o_maddr[1], o_mwe[1]);
      rp3[1] <= rp3[0];
      rp3[2] <= rp3[1];
    end
  end

  assign m_rvalid[0] = rp1.v | inject;
  assign m_err[0]    = inject ? 1'b0 : rp1.e;
  assign m_rdata[0]  = inject ? 32'hDEAD_BEEF : rp1.d;
  assign m_rvalid[1] = rp3[2].v | inject;
  assign m_err[1]    = inject ? 1'b0 : rp3[2].e;
  assign m_rdata[1]  = inject ? 32'hDEAD_BEEF : rp3[2].d;

  task automatic chk(input int j, input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL lat%0d %s: actual %h required %h", lat(j), nm, act, exp);
    end
  endtask

  // Expected grant now and response (or mismatch if dropped) LAT cycles later.
  task automatic push_exp(input logic [1:0] eg);
    gexp_t g;
    rexp_t r;
    logic  k;
    k = eg[1];
    g.cyc = cyc_n; g.gnt = eg; g.a = addr[k]; g.w = we[k]; g.b = be[k]; g.d = wdata[k];
    r.gnt = eg;
    r.e   = (addr[k][31:16] == 16'hBAD0);
    r.d   = we[k] ? 32'h0 : sram_word(addr[k]);
    for (int j = 0; j < 2; j++) begin
      qg[j].push_back(g);
      if (drop) qm[j].push_back(cyc_n + lat(j));
      else begin
        r.cyc = cyc_n + lat(j);
        qr[j].push_back(r);
      end
    end
  endtask

  task automatic step(input logic [1:0] r, input logic [1:0] l, input logic [1:0] eg,
                      input logic [31:0] a0, input logic [31:0] a1);
    req = r; lock = l; addr[0] = a0; addr[1] = a1;
    if (eg != 2'b00) push_exp(eg);
    $display("cycle %0d: req=%b lock=%b expect gnt=%b", cyc_n, r, l, eg);
    @(posedge clk); #1;
  endtask

  task automatic chk_rst();
    for (int j = 0; j < 2; j++)
      chk(j, "outputs in reset", 128'({o_gnt[j], o_rvalid[j], o_err[j], o_rdata[j], o_mreq[j],
          o_maddr[j], o_mwe[j], o_mbe[j], o_mwd[j], o_mism[j]}), 128'(0));
  endtask

  // Monitor: compare whatever the DUT presents against the scoreboard queues.
  task automatic mon(input int j);
    gexp_t g;
    rexp_t r;
    int    m;
    if (o_gnt[j] != 2'b00) begin
      if (qg[j].size() == 0) chk(j, "unexpected grant", 128'(o_gnt[j]), 128'(0));
      else begin
        g = qg[j].pop_front();
        chk(j, "grant", 128'({cyc_n, o_gnt[j], o_mreq[j], o_maddr[j], o_mwe[j], o_mbe[j], o_mwd[j]}),
            128'({g.cyc, g.gnt, 1'b1, g.a, g.w, g.b, g.d}));
      end
    end else begin
      chk(j, "idle bus", 128'({o_mreq[j], o_maddr[j], o_mwe[j], o_mbe[j], o_mwd[j]}), 128'(0));
      if (qg[j].size() != 0 && qg[j][0].cyc <= cyc_n) begin
        g = qg[j].pop_front();
        chk(j, "missing grant", 128'({cyc_n, o_gnt[j]}), 128'({g.cyc, g.gnt}));
      end
    end
    if (o_rvalid[j] != 2'b00) begin
      if (qr[j].size() == 0) chk(j, "unexpected rvalid", 128'(o_rvalid[j]), 128'(0));
      else begin
        r = qr[j].pop_front();
        chk(j, "response", 128'({cyc_n, o_rvalid[j], o_rdata[j], o_err[j]}),
            128'({r.cyc, r.gnt, r.d, r.e}));
      end
    end else if (qr[j].size() != 0 && qr[j][0].cyc <= cyc_n) begin
      r = qr[j].pop_front();
      chk(j, "missing response", 128'({cyc_n, o_rvalid[j]}), 128'({r.cyc, r.gnt}));
    end
    if (o_mism[j]) begin
      if (qm[j].size() == 0) chk(j, "unexpected mismatch", 128'(o_mism[j]), 128'(0));
      else begin
        m = qm[j].pop_front();
        chk(j, "mismatch cycle", 128'(cyc_n), 128'(m));
      end
    end else if (qm[j].size() != 0 && qm[j][0] <= cyc_n) begin
      m = qm[j].pop_front();
      chk(j, "missing mismatch", 128'({cyc_n, o_mism[j]}), 128'({m, 1'b1}));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req = '0; lock = '0; addr = '0; we = '0; wdata = '0;
    be = {4'hF, 4'h3}; inject = 1'b0; drop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Requests pending during reset must not produce a grant or bus activity.
    req = 2'b11; addr[0] = 32'h10; addr[1] = 32'h20;
    #1;
    chk_rst();
    req = 2'b00;
    rst = 1'b0;
    @(posedge clk); #1;

    // Fair alternation with both requesting.
    step(2'b11, 2'b00, 2'b01, 32'h0000_0100, 32'h0000_0200);
    step(2'b11, 2'b00, 2'b10, 32'h0000_0104, 32'h0000_0200);
    step(2'b11, 2'b00, 2'b01, 32'h0000_0104, 32'h0000_0204);
    step(2'b11, 2'b00, 2'b10, 32'h0000_0108, 32'h0000_0204);
    step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);

    // Requester 0 locks for two accesses, then the pointer lands on 1.
    step(2'b11, 2'b01, 2'b01, 32'h0000_0300, 32'h0000_0400);
    step(2'b11, 2'b01, 2'b01, 32'h0000_0304, 32'h0000_0400);
    step(2'b11, 2'b00, 2'b01, 32'h0000_0308, 32'h0000_0400);
    step(2'b11, 2'b00, 2'b10, 32'h0000_030C, 32'h0000_0400);
    step(2'b11, 2'b00, 2'b01, 32'h0000_030C, 32'h0000_0404);
    // Requester 1 locks, then drops its request: no grant that cycle, ptr -> 0.
    step(2'b11, 2'b10, 2'b10, 32'h0000_0310, 32'h0000_0408);
    step(2'b01, 2'b00, 2'b00, 32'h0000_0310, 32'h0);
    step(2'b11, 2'b00, 2'b01, 32'h0000_0310, 32'h0000_040C);

    // Register write from requester 1.
    we[1] = 1'b1; wdata[1] = 32'h0000_0041;
    step(2'b10, 2'b00, 2'b10, 32'h0, 32'hFF00_0000);
    we[1] = 1'b0; wdata[1] = 32'h0;
    // Read that the memory answers with an error.
    step(2'b01, 2'b00, 2'b01, 32'hBAD0_0010, 32'h0);
    repeat (3) step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);

    // Stray response on an empty pipe.
    inject = 1'b1;
    for (int j = 0; j < 2; j++) qm[j].push_back(cyc_n);
    step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
    inject = 1'b0;
    // Response that never arrives.
    drop = 1'b1;
    step(2'b01, 2'b00, 2'b01, 32'h0000_0500, 32'h0);
    drop = 1'b0;
    repeat (4) step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);

    // Reset with responses outstanding; leave the pointer at 1 beforehand.
    step(2'b10, 2'b00, 2'b10, 32'h0, 32'h0000_0600);
    step(2'b01, 2'b00, 2'b01, 32'h0000_0604, 32'h0);
    req = 2'b11; addr[0] = 32'h0000_0608; addr[1] = 32'h0000_0700;
    #2;
    rst = 1'b1;
    #1;
    chk_rst();
    for (int j = 0; j < 2; j++) begin
      qr[j].delete();
      qm[j].delete();
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    req = 2'b00;
    rst = 1'b0;
    @(posedge clk); #1;
    step(2'b11, 2'b00, 2'b01, 32'h0000_0800, 32'h0000_0900);
    repeat (5) step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);

    for (int j = 0; j < 2; j++)
      chk(j, "scoreboard drained", 128'({32'(qg[j].size()), 32'(qr[j].size()), 32'(qm[j].size())}), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
